// File: rtl/chan_dump_ctrl.sv
// Dumps one capture channel RAM (CH1..CH5) through UART_tx, oldest sample first.
// Optional header byte {5'b10100,chan} ahead of the data when DUMP_HDR_EN is defined.
module chan_dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_req,
  input  logic [2:0]      dump_chan,
  input  logic [LOG2-1:0] trace_end,
  output logic            ram_en,
  output logic [LOG2-1:0] ram_addr,
  input  logic [39:0]     ram_rdata,
  output logic [7:0]      tx_data,
  output logic            trmt,
  input  logic            tx_done,
  output logic            dump_busy,
  output logic            dump_done,
  output logic            bad_chan
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  typedef enum logic [2:0] {
    IDLE,
`ifdef DUMP_HDR_EN
    HDR,
    HDR_WAIT,
`endif
    RD,
    LAT,
    WAIT_TX,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      chan_q, chan_d;
  logic [LOG2-1:0] addr_q, addr_d;
  logic [LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            bad_chan_q, bad_chan_d;
  logic            chan_ok;
  logic [7:0]      sel_byte;

  assign chan_ok = (dump_chan != 3'd0) && (dump_chan <= 3'd5);

  always_comb begin
    case (chan_q)
      3'd1:    sel_byte = ram_rdata[7:0];
      3'd2:    sel_byte = ram_rdata[15:8];
      3'd3:    sel_byte = ram_rdata[23:16];
      3'd4:    sel_byte = ram_rdata[31:24];
      3'd5:    sel_byte = ram_rdata[39:32];
      default: sel_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    bad_chan_d = 1'b0;
    tx_data    = tx_data_q;
    trmt       = 1'b0;
    ram_en     = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (dump_req) begin
          if (chan_ok) begin
            chan_d = dump_chan;
            // Out-of-range start pointers restart from the bottom of the RAM.
            addr_d = (trace_end > LAST) ? '0 : trace_end;
            cnt_d  = '0;
`ifdef DUMP_HDR_EN
            state_d = HDR;
`else
            state_d = RD;
`endif
          end else begin
            bad_chan_d = 1'b1;
          end
        end
      end
`ifdef DUMP_HDR_EN
      HDR: begin
        dump_busy = 1'b1;
        trmt      = 1'b1;
        tx_data_d = {5'b10100, chan_q};
        tx_data   = tx_data_d;
        state_d   = HDR_WAIT;
      end
      HDR_WAIT: begin
        dump_busy = 1'b1;
        if (tx_done) state_d = RD;
      end
`endif
      RD: begin
        dump_busy = 1'b1;
        ram_en    = 1'b1;
        state_d   = LAT;
      end
      LAT: begin
        // RAM data arrives this cycle; present it alongside trmt and hold it after.
        dump_busy = 1'b1;
        trmt      = 1'b1;
        tx_data_d = sel_byte;
        tx_data   = sel_byte;
        state_d   = WAIT_TX;
      end
      WAIT_TX: begin
        dump_busy = 1'b1;
        if (tx_done) begin
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = (addr_q == LAST) ? '0 : addr_q + 1'b1;
            state_d = RD;
          end
        end
      end
      DONE: begin
        dump_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      chan_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      bad_chan_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      bad_chan_q <= bad_chan_d;
    end
  end

  assign ram_addr = addr_q;
  assign bad_chan = bad_chan_q;

endmodule

// File: tb/tb_chan_dump_ctrl.sv
// Directed bench for chan_dump_ctrl: RAM model, fixed-latency UART responder, per-byte checks.
// Header-byte expectations follow DUMP_HDR_EN.
module tb_chan_dump_ctrl;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dump_req;
  logic [2:0]      dump_chan;
  logic [LOG2-1:0] trace_end;
  logic            ram_en;
  logic [LOG2-1:0] ram_addr;
  logic [39:0]     ram_rdata;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            tx_done;
  logic            dump_busy;
  logic            dump_done;
  logic            bad_chan;

  int n_checks = 0;
  int n_fail   = 0;
  int oob_cnt  = 0;

  logic [7:0] mem [1:5][0:ENTRIES-1];

  chan_dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dump_req  (dump_req),
    .dump_chan (dump_chan),
    .trace_end (trace_end),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .tx_data   (tx_data),
    .trmt      (trmt),
    .tx_done   (tx_done),
    .dump_busy (dump_busy),
    .dump_done (dump_done),
    .bad_chan  (bad_chan)
  );

  always #5 clk = ~clk;

  // Synchronous channel RAMs, one clock read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (int'(ram_addr) >= ENTRIES) begin
        oob_cnt <= oob_cnt + 1;
        ram_rdata <= '0;
      end else begin
        ram_rdata <= {mem[5][ram_addr], mem[4][ram_addr], mem[3][ram_addr],
                      mem[2][ram_addr], mem[1][ram_addr]};
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int ch, input int a);
    int v;
    v = (ch == 1) ? a : (a * 3 + ch * 29);
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART responder: tx_done seen by the DUT 10 clocks after trmt; tx_data must hold meanwhile.
  task automatic uart_wait(input logic [7:0] held, inout int stray);
    for (int i = 0; i < 9; i++) begin
      tick();
      dump_req = 1'b0;
      if (trmt || ram_en || dump_done || tx_data !== held) stray++;
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic run_dump(input int ch, input int te, input int inject_at, input int abort_at);
    int start;
    int a;
    int stray;
    logic [7:0] eb;
    start = (te >= ENTRIES) ? 0 : te;
    stray = 0;
    dump_chan = 3'(ch);
    trace_end = LOG2'(te);
    dump_req  = 1'b1;
    tick();
    dump_req  = 1'b0;
`ifdef DUMP_HDR_EN
    eb = 8'hA0 | 8'(ch);
    check("hdr_trmt", {trmt, tx_data}, {1'b1, eb});
    uart_wait(eb, stray);
`endif
    for (int b = 0; b < ENTRIES; b++) begin
      a = (start + b) % ENTRIES;
      check("rd_addr", {dump_busy, ram_en, trmt, ram_addr}, {1'b1, 1'b1, 1'b0, LOG2'(a)});
      tick();
      eb = exp_byte(ch, a);
      check("tx_byte", {ram_en, trmt, tx_data}, {1'b0, 1'b1, eb});
      if (b == inject_at) begin
        dump_chan = 3'd2;
        dump_req  = 1'b1;
      end
      if (b == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_outs", {ram_en, trmt, dump_busy, dump_done, bad_chan, tx_data, ram_addr},
              '0);
        for (int i = 0; i < 3; i++) begin
          tick();
          if (dump_done || dump_busy || trmt) stray++;
        end
        check("rst_quiet", stray, 0);
        rst_n = 1'b1;
        tick();
        return;
      end
      uart_wait(eb, stray);
    end
    check("done_pulse", {dump_done, dump_busy}, 2'b10);
    tick();
    check("idle_after", {dump_done, dump_busy, trmt, ram_en}, 4'b0000);
    check("no_stray", stray, 0);
  endtask

  initial begin
    for (int c = 1; c <= 5; c++)
      for (int i = 0; i < ENTRIES; i++)
        mem[c][i] = exp_byte(c, i);

    rst_n     = 1'b0;
    dump_req  = 1'b0;
    dump_chan = '0;
    trace_end = '0;
    tx_done   = 1'b0;
    ram_rdata = '0;
    repeat (3) tick();
    check("reset_outs", {ram_en, trmt, dump_busy, dump_done, bad_chan, tx_data, ram_addr}, '0);
    rst_n = 1'b1;
    tick();

    // Invalid channels, plus a stray tx_done while idle.
    for (int k = 0; k < 2; k++) begin
      dump_chan = (k == 0) ? 3'd0 : 3'd6;
      dump_req  = 1'b1;
      tick();
      dump_req  = 1'b0;
      check("bad_chan", {bad_chan, dump_busy, trmt, ram_en}, 4'b1000);
      tick();
      check("bad_clear", {bad_chan, dump_busy, trmt, ram_en}, 4'b0000);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    check("idle_txdone", {dump_busy, trmt, ram_en, dump_done}, 4'b0000);

    run_dump(1, 0, -1, -1);
    run_dump(3, 200, -1, -1);
    run_dump(5, 400, 50, -1);
    run_dump(4, 50, -1, 100);
    run_dump(4, 50, -1, -1);
    check("oob_addr", oob_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
